cmd_parser_mc: RTL and testbench

Multi-channel, parametrised UART command parser for the MD5 string-match pipeline. It sits between the uart_rx/uart_tx byte interfaces and NUM_CH string_process_match/md5core channels. It loads per-channel target hashes, broadcasts the text string to all channels, and returns match results. It adds to the single-channel parser a channel-select byte, a status command, NAK responses and an inter-byte timeout.

---
 rtl/cmd_parser_pkg.sv | 28 ++
 rtl/tx_byte_sched.sv | 59 +++++
 rtl/cmd_parser_mc.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_cmd_parser_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_parser_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the command parser.
// Pure declarations; no logic, no latency.
// Imported by the parser top and its sub-modules.
package cmd_parser_pkg;

  localparam logic [7:0] CMD_SET_HASH   = 8'h01;
  localparam logic [7:0] CMD_SEND_STR   = 8'h02;
  localparam logic [7:0] CMD_READ_MATCH = 8'h03;
  localparam logic [7:0] CMD_STATUS     = 8'h04;

  localparam logic [7:0] ACK         = 8'h01;
  localparam logic [7:0] NAK         = 8'hEE;
  localparam logic [7:0] NAK_TIMEOUT = 8'hEF;

  // IDLE must stay at zero so the state nibble on the LEDs reads 0 out of reset
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    GET_CH    = 4'd1,
    GET_HASH  = 4'd2,
    GET_LEN   = 4'd3,
    STREAM    = 4'd4,
    WAIT_DONE = 4'd5,
    RD_MATCH  = 4'd6,
    TX_RESP   = 4'd7,
    TX_WAIT   = 4'd8
  } state_e;

endpackage

// File: rtl/tx_byte_sched.sv
// Paces response bytes onto the uart_tx start/data strobe interface.
// Latency: a byte accepted on edge N can strobe txd_start from edge N+1 onward.
// Backpressure: one-byte holding register; byte_rdy_o is low while a byte waits.
module tx_byte_sched (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       byte_vld_i,
  input  logic [7:0] byte_dat_i,
  output logic       byte_rdy_o,
  output logic       idle_o,
  input  logic       txd_busy_i,
  output logic       txd_start_o,
  output logic [7:0] txd_data_o
);

  logic       pend_q, pend_d;
  logic [7:0] hold_q, hold_d;
  logic       start_q, start_d;
  logic [7:0] data_q, data_d;

  assign byte_rdy_o  = !pend_q;
  // Idle means nothing held, no strobe in flight and the transmitter is free
  assign idle_o      = !pend_q && !start_q && !txd_busy_i;
  assign txd_start_o = start_q;
  assign txd_data_o  = data_q;

  // Issue the held byte when the transmitter is free and no strobe went out last cycle
  always_comb begin
    pend_d  = pend_q;
    hold_d  = hold_q;
    start_d = 1'b0;
    data_d  = data_q;
    if (pend_q && !txd_busy_i && !start_q) begin
      start_d = 1'b1;
      data_d  = hold_q;
      pend_d  = 1'b0;
    end
    if (byte_vld_i && !pend_q) begin
      pend_d = 1'b1;
      hold_d = byte_dat_i;
    end
  end

  // Holding register and strobe outputs, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pend_q  <= 1'b0;
      hold_q  <= 8'h00;
      start_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cmd_parser_mc.sv
// Multi-channel UART command parser: loads hashes, broadcasts strings, returns match results.
// Latency: hash_we/str_valid/str_start 1 cycle after the triggering rx strobe; responses 1-2 cycles later.
// Backpressure: none on rx (bytes arriving while responding are dropped and flagged); tx waits on txd_busy.
module cmd_parser_mc
  import cmd_parser_pkg::*;
#(
  parameter int HASH_BITS      = 128,
  parameter int NUM_CH         = 4,
  parameter int MATCH_BYTES    = 19,
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rxd_data,
  input  logic                    rxd_data_ready,
  input  logic                    txd_busy,
  output logic                    txd_start,
  output logic [7:0]              txd_data,
  output logic [HASH_BITS-1:0]    hash_data,
  output logic [NUM_CH-1:0]       hash_we,
  output logic                    str_start,
  output logic [7:0]              str_data,
  output logic                    str_valid,
  output logic                    str_last,
  input  logic [NUM_CH-1:0]       proc_done,
  input  logic [NUM_CH-1:0]       match_found,
  input  logic [16*NUM_CH-1:0]    match_pos,
  output logic [$clog2(NUM_CH):0] match_sel,
  output logic [7:0]              match_rd_addr,
  input  logic [7:0]              match_rd_data,
  output logic [7:0]              leds
);

  localparam int              HASH_BYTES = HASH_BITS / 8;
  localparam int              SELW       = $clog2(NUM_CH) + 1;
  localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      NUM_CH_B   = 8'(NUM_CH);
  localparam logic [15:0]     HASH_LAST  = 16'(HASH_BYTES - 1);
  // READ_MATCH response index of the final byte: 3 header bytes then the string
  localparam logic [15:0]     RESP_LAST  = 16'(MATCH_BYTES + 2);
  localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            ch_q, ch_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           len_q, len_d;
  logic [HASH_BITS-1:0]  hash_q, hash_d;
  logic [NUM_CH-1:0]     hash_we_q, hash_we_d;
  logic                  str_start_q, str_start_d;
  logic                  str_valid_q, str_valid_d;
  logic                  str_last_q, str_last_d;
  logic [7:0]            str_data_q, str_data_d;
  logic [SELW-1:0]       sel_q, sel_d;
  logic [7:0]            rd_addr_q, rd_addr_d;
  logic [7:0]            resp_q, resp_d;
  logic                  use_rd_q, use_rd_d;
  logic                  more_q, more_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  nak_q, nak_d;
  logic                  tmo_seen_q, tmo_seen_d;
  logic                  ovr_q, ovr_d;

  logic                  tx_vld, tx_rdy, tx_idle;
  logic [7:0]            tx_dat;
  logic                  timed, tmo_hit;
  logic                  found_sel;
  logic [15:0]           pos_sel;
  logic [NUM_CH-1:0]     ch_onehot;

  tx_byte_sched u_tx (
    .clk_i       (clk),
    .reset_ni    (reset),
    .byte_vld_i  (tx_vld),
    .byte_dat_i  (tx_dat),
    .byte_rdy_o  (tx_rdy),
    .idle_o      (tx_idle),
    .txd_busy_i  (txd_busy),
    .txd_start_o (txd_start),
    .txd_data_o  (txd_data)
  );

  // Per-channel views of the latched channel byte; an out-of-range channel selects nothing
  always_comb begin
    found_sel = 1'b0;
    pos_sel   = 16'h0000;
    ch_onehot = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == 8'(c)) begin
        found_sel    = match_found[c];
        pos_sel      = match_pos[16*c +: 16];
        ch_onehot[c] = 1'b1;
      end
    end
  end

  // Next-state and datapath: command decode, byte counting, response sequencing, timeout
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    hash_d      = hash_q;
    hash_we_d   = '0;
    str_start_d = 1'b0;
    str_valid_d = 1'b0;
    str_last_d  = 1'b0;
    str_data_d  = str_data_q;
    sel_d       = sel_q;
    rd_addr_d   = rd_addr_q;
    resp_d      = resp_q;
    use_rd_d    = use_rd_q;
    more_d      = more_q;
    nak_d       = nak_q;
    tmo_seen_d  = tmo_seen_q;
    ovr_d       = ovr_q;
    tx_vld      = 1'b0;
    tx_dat      = use_rd_q ? match_rd_data : resp_q;

    // The inter-byte timer only runs while a command is waiting for more input
    timed   = (state_q == GET_CH) || (state_q == GET_HASH) ||
              (state_q == GET_LEN) || (state_q == STREAM);
    tmo_d   = (rxd_data_ready || !timed) ? '0 : tmo_q + TW'(1);
    tmo_hit = timed && !rxd_data_ready && (tmo_q == TMO_LAST);

    if (rxd_data_ready && ((state_q == WAIT_DONE) || (state_q == RD_MATCH) ||
                           (state_q == TX_RESP) || (state_q == TX_WAIT))) begin
      ovr_d = 1'b1;
    end

    if (tmo_hit) begin
      // Abandoned command: a stream in progress gets no str_last, the next str_start restarts it
      resp_d     = NAK_TIMEOUT;
      tmo_seen_d = 1'b1;
      state_d    = TX_RESP;
    end else begin
      case (state_q)
        IDLE: begin
          if (rxd_data_ready) begin
            cmd_d = rxd_data;
            cnt_d = 16'h0000;
            case (rxd_data)
              CMD_SET_HASH, CMD_READ_MATCH: state_d = GET_CH;
              CMD_SEND_STR:                 state_d = GET_LEN;
              CMD_STATUS: begin
                resp_d  = 8'(match_found);
                state_d = TX_RESP;
              end
              default: begin
                resp_d  = NAK;
                nak_d   = 1'b1;
                state_d = TX_RESP;
              end
            endcase
          end
        end
        GET_CH: begin
          if (rxd_data_ready) begin
            ch_d  = rxd_data;
            cnt_d = 16'h0000;
            if (cmd_q == CMD_SET_HASH) begin
              state_d = GET_HASH;
            end else if (rxd_data < NUM_CH_B) begin
              sel_d   = rxd_data[SELW-1:0];
              state_d = RD_MATCH;
            end else begin
              resp_d  = NAK;
              nak_d   = 1'b1;
              state_d = TX_RESP;
            end
          end
        end
        GET_HASH: begin
          if (rxd_data_ready) begin
            hash_d = (hash_q << 8) | HASH_BITS'(rxd_data);
            cnt_d  = cnt_q + 16'd1;
            if (cnt_q == HASH_LAST) begin
              // Bad channel still consumes every hash byte but writes nothing
              hash_we_d = ch_onehot;
              if (ch_q < NUM_CH_B) begin
                resp_d = ACK;
              end else begin
                resp_d = NAK;
                nak_d  = 1'b1;
              end
              state_d = TX_RESP;
            end
          end
        end
        GET_LEN: begin
          if (rxd_data_ready) begin
            if (cnt_q == 16'h0000) begin
              len_d = {rxd_data, len_q[7:0]};
              cnt_d = 16'd1;
            end else begin
              len_d = {len_q[15:8], rxd_data};
              cnt_d = 16'h0000;
              if ({len_q[15:8], rxd_data} == 16'h0000) begin
                resp_d  = ACK;
                state_d = TX_RESP;
              end else begin
                str_start_d = 1'b1;
                state_d     = STREAM;
              end
            end
          end
        end
        STREAM: begin
          if (rxd_data_ready) begin
            str_valid_d = 1'b1;
            str_data_d  = rxd_data;
            cnt_d       = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == len_q) begin
              str_last_d = 1'b1;
              state_d    = WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (&proc_done) begin
            resp_d  = ACK;
            state_d = TX_RESP;
          end
        end
        RD_MATCH: begin
          // One cycle here covers the synchronous read of the address set on entry
          case (cnt_q)
            16'd0:   resp_d = {7'b0, found_sel};
            16'd1:   resp_d = pos_sel[15:8];
            16'd2:   resp_d = pos_sel[7:0];
            default: resp_d = 8'h00;
          endcase
          use_rd_d = (cnt_q > 16'd2);
          more_d   = (cnt_q != RESP_LAST);
          state_d  = TX_RESP;
        end
        TX_RESP: begin
          tx_vld = 1'b1;
          if (tx_rdy) begin
            state_d  = more_q ? TX_WAIT : IDLE;
            use_rd_d = 1'b0;
            more_d   = 1'b0;
          end
        end
        TX_WAIT: begin
          if (tx_idle) begin
            cnt_d     = cnt_q + 16'd1;
            rd_addr_d = 8'(cnt_q - 16'd2);
            state_d   = RD_MATCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, output and sticky-flag registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_q       <= 8'h00;
      ch_q        <= 8'h00;
      cnt_q       <= 16'h0000;
      len_q       <= 16'h0000;
      hash_q      <= '0;
      hash_we_q   <= '0;
      str_start_q <= 1'b0;
      str_valid_q <= 1'b0;
      str_last_q  <= 1'b0;
      str_data_q  <= 8'h00;
      sel_q       <= '0;
      rd_addr_q   <= 8'h00;
      resp_q      <= 8'h00;
      use_rd_q    <= 1'b0;
      more_q      <= 1'b0;
      tmo_q       <= '0;
      nak_q       <= 1'b0;
      tmo_seen_q  <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      hash_q      <= hash_d;
      hash_we_q   <= hash_we_d;
      str_start_q <= str_start_d;
      str_valid_q <= str_valid_d;
      str_last_q  <= str_last_d;
      str_data_q  <= str_data_d;
      sel_q       <= sel_d;
      rd_addr_q   <= rd_addr_d;
      resp_q      <= resp_d;
      use_rd_q    <= use_rd_d;
      more_q      <= more_d;
      tmo_q       <= tmo_d;
      nak_q       <= nak_d;
      tmo_seen_q  <= tmo_seen_d;
      ovr_q       <= ovr_d;
    end
  end

  assign hash_data     = hash_q;
  assign hash_we       = hash_we_q;
  assign str_start     = str_start_q;
  assign str_valid     = str_valid_q;
  assign str_last      = str_last_q;
  assign str_data      = str_data_q;
  assign match_sel     = sel_q;
  assign match_rd_addr = rd_addr_q;
  assign leds          = {state_q, nak_q, tmo_seen_q, ovr_q, (state_q != IDLE)};

endmodule

// File: tb/tb_cmd_parser_mc.sv
module tb_cmd_parser_mc;

  localparam int HB  = 128;
  localparam int NCH = 4;
  localparam int MB  = 19;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rxd_data;
  logic          rxd_data_ready;
  logic          txd_busy;
  logic          txd_start;
  logic [7:0]    txd_data;
  logic [HB-1:0] hash_data;
  logic [NCH-1:0] hash_we;
  logic          str_start;
  logic [7:0]    str_data;
  logic          str_valid;
  logic          str_last;
  logic [NCH-1:0] proc_done;
  logic [NCH-1:0] match_found;
  logic [16*NCH-1:0] match_pos;
  logic [2:0]    match_sel;
  logic [7:0]    match_rd_addr;
  logic [7:0]    match_rd_data;
  logic [7:0]    leds;

  always #5 clk = ~clk;

  cmd_parser_mc #(
    .HASH_BITS(HB), .NUM_CH(NCH), .MATCH_BYTES(MB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rxd_data(rxd_data), .rxd_data_ready(rxd_data_ready),
    .txd_busy(txd_busy), .txd_start(txd_start), .txd_data(txd_data),
    .hash_data(hash_data), .hash_we(hash_we), .str_start(str_start),
    .str_data(str_data), .str_valid(str_valid), .str_last(str_last),
    .proc_done(proc_done), .match_found(match_found), .match_pos(match_pos),
    .match_sel(match_sel), .match_rd_addr(match_rd_addr),
    .match_rd_data(match_rd_data), .leds(leds)
  );

  typedef struct {
    logic [NCH-1:0] we;
    logic [HB-1:0]  dat;
  } hexp_t;

  logic [7:0] exp_tx[$];
  hexp_t      exp_h[$];
  logic [8:0] exp_s[$];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    strobe_cyc = 0;
  int    last_tx_cyc = 0;
  int    n_start = 0;
  int    n_valid = 0;
  int    busy_cnt = 0;
  logic  prev_start = 1'b0;

  string msg = "Hello. The quick brown fox jumps over the lazy dog.";
  string fox = "The quick brown fox";
  logic [HB-1:0] h_fox = 128'ha2004f37730b9445670a738fa0fc9ee5;
  logic [HB-1:0] h_alt = 128'h0123456789abcdeffedcba9876543210;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Channel match-string memory: channel 0 holds the fox string, others a pattern
  function automatic logic [7:0] mem_rd(input logic [2:0] sel, input logic [7:0] addr);
    if (sel == 3'd0 && addr < 8'd19) return fox[addr];
    return (addr * 8'd3) ^ {5'b0, sel} ^ 8'h40;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) match_rd_data <= mem_rd(match_sel, match_rd_addr);

  // Transmit side: score bytes, check pacing, model uart_tx busy
  always @(negedge clk) begin
    if (reset && txd_start) begin
      check("tx_busy_clear", txd_busy, 0);
      check("tx_spacing", prev_start, 0);
      check("tx_queued", exp_tx.size() != 0, 1);
      if (exp_tx.size() != 0) check("txd_data", txd_data, exp_tx.pop_front());
      last_tx_cyc = cyc;
      txd_busy = 1'b1;
      busy_cnt = 6;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) txd_busy = 1'b0;
    end
    prev_start = txd_start;
  end

  // Hash write and string broadcast monitors
  always @(negedge clk) begin
    if (reset && hash_we != '0) begin
      hexp_t e;
      check("hash_queued", exp_h.size() != 0, 1);
      if (exp_h.size() != 0) begin
        e = exp_h.pop_front();
        check("hash_we", hash_we, e.we);
        check("hash_data", hash_data, e.dat);
      end
      check("hash_we_lat", cyc - strobe_cyc, 1);
    end
    if (reset && str_start) begin
      n_start++;
      check("str_start_lat", cyc - strobe_cyc, 1);
    end
    if (reset && str_valid) begin
      n_valid++;
      check("str_queued", exp_s.size() != 0, 1);
      if (exp_s.size() != 0) check("str_last_data", {str_last, str_data}, exp_s.pop_front());
      check("str_valid_lat", cyc - strobe_cyc, 1);
    end
    if (reset && str_last && !str_valid) check("str_last_valid", str_valid, 1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rxd_data = b;
    rxd_data_ready = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk); #1;
    rxd_data_ready = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_hash(input logic [7:0] ch, input logic [HB-1:0] h);
    send_byte(8'h01);
    send_byte(ch);
    for (int i = 0; i < HB/8; i++) send_byte(h[HB-1-8*i -: 8]);
  endtask

  task automatic push_read(input int ch);
    logic [15:0] p;
    p = match_pos[16*ch +: 16];
    exp_tx.push_back({7'b0, match_found[ch]});
    exp_tx.push_back(p[15:8]);
    exp_tx.push_back(p[7:0]);
    for (int i = 0; i < MB; i++) exp_tx.push_back(mem_rd(3'(ch), 8'(i)));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_tx.size() + exp_h.size() + exp_s.size()) != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_drain"}, exp_tx.size() + exp_h.size() + exp_s.size(), 0);
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_idle"}, leds[7:4], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    rxd_data = 8'h00;
    rxd_data_ready = 1'b0;
    txd_busy = 1'b0;
    proc_done = 4'b1111;
    match_found = 4'b0001;
    match_pos = {16'h5a5a, 16'habcd, 16'h1234, 16'h0007};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_txd", {txd_start, txd_data}, 0);
    check("rst_hash", hash_data, 0);
    check("rst_hash_we", hash_we, 0);
    check("rst_str", {str_start, str_valid, str_last, str_data}, 0);
    check("rst_match", {match_sel, match_rd_addr}, 0);
    check("rst_leds", leds, 8'h00);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // SET_HASH channel 0
    exp_h.push_back('{we: 4'b0001, dat: h_fox});
    exp_tx.push_back(8'h01);
    send_hash(8'h00, h_fox);
    drain("set_hash0");

    // SEND_STR, 51 bytes
    for (int i = 0; i < msg.len(); i++) exp_s.push_back({(i == msg.len() - 1), msg[i]});
    exp_tx.push_back(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h33);
    for (int i = 0; i < msg.len(); i++) send_byte(msg[i]);
    drain("send_str");
    check("str_start_cnt", n_start, 1);
    check("str_valid_cnt", n_valid, 51);

    // READ_MATCH channel 0, then STATUS
    push_read(0);
    send_byte(8'h03);
    send_byte(8'h00);
    drain("read_ch0");
    exp_tx.push_back(8'h01);
    send_byte(8'h04);
    drain("status1");

    // READ_MATCH channel 2 exercises the read mux select
    push_read(2);
    send_byte(8'h03);
    send_byte(8'h02);
    drain("read_ch2");

    match_found = 4'b1010;
    exp_tx.push_back(8'h0a);
    send_byte(8'h04);
    drain("status2");

    // Error responses
    exp_tx.push_back(8'hEE);
    send_byte(8'h03);
    send_byte(8'h05);
    drain("read_ch5");
    exp_tx.push_back(8'hEE);
    send_byte(8'h7F);
    drain("bad_op");
    check("nak_led", leds[3], 1);

    // Zero-length string: ACK, no stream activity
    exp_tx.push_back(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    drain("len0");
    check("len0_start", n_start, 1);
    check("len0_valid", n_valid, 51);

    // SET_HASH to a nonexistent channel consumes all bytes and NAKs
    exp_tx.push_back(8'hEE);
    send_hash(8'h04, h_alt);
    drain("set_hash4");

    // Byte arriving mid-response is dropped and flagged
    check("ovr_before", leds[1], 0);
    push_read(1);
    send_byte(8'h03);
    send_byte(8'h01);
    repeat (20) @(posedge clk);
    send_byte(8'h04);
    drain("overrun");
    check("ovr_led", leds[1], 1);

    // Inter-byte timeout inside SET_HASH
    check("tmo_before", leds[2], 0);
    exp_tx.push_back(8'hEF);
    send_byte(8'h01);
    send_byte(8'h00);
    drain("timeout");
    check("tmo_lat_window", (last_tx_cyc - strobe_cyc >= 100) && (last_tx_cyc - strobe_cyc <= 104), 1);
    check("tmo_led", leds[2], 1);

    // Parser recovers: full SET_HASH on channel 1
    exp_h.push_back('{we: 4'b0010, dat: h_alt});
    exp_tx.push_back(8'h01);
    send_hash(8'h01, h_alt);
    drain("set_hash1");
    check("final_leds", leds, 8'h0E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
